// File: rtl/mux_2to1_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_2to1_if
//  Description : Bundles the mux operands, select, valid qualifier and the
//                muxed result. The master drives the operands and consumes
//                the result. The slave (the mux) does the reverse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_2to1_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] inputA;
    logic [WIDTH-1:0] inputB;
    logic             controlSignal;
    logic             inValid;
    logic [WIDTH-1:0] outMux;
    logic             outValid;

    modport master (
        output inputA,
        output inputB,
        output controlSignal,
        output inValid,
        input  outMux,
        input  outValid
    );

    modport slave (
        input  inputA,
        input  inputB,
        input  controlSignal,
        input  inValid,
        output outMux,
        output outValid
    );
endinterface
`default_nettype wire

// File: rtl/mux_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_2to1
//  Description : WIDTH-bit two-input multiplexer with a valid qualifier.
//                controlSignal == 1 selects inputB. Any other value, including
//                X/Z, selects inputA.
//                Configuration macro MUX_OUT_REG_EN:
//                  undefined - purely combinational. outMux follows the
//                              selection and outValid follows inValid.
//                              clk and reset are unused.
//                  defined   - one register stage with 1-cycle latency.
//                              It uses a synchronous active-high reset.
//                              outMux holds its value while inValid is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_2to1 #(
    parameter int WIDTH = 64
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mux_2to1_if.slave     bus
);

    logic [WIDTH-1:0] w_selected;

    // An if-statement makes an unknown select take the inputA branch.
    // A ?: operator would instead merge the two operands bit by bit.
    always_comb begin
        w_selected = bus.inputA;
        if (bus.controlSignal == 1'b1) begin
            w_selected = bus.inputB;
        end
    end

`ifdef MUX_OUT_REG_EN

    logic [WIDTH-1:0] r_outMux;
    logic             r_outValid;

    // Output stage. Reset wins over a valid transfer.
    // An idle cycle keeps the data and drops valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outMux   <= '0;
            r_outValid <= 1'b0;
        end else if (bus.inValid) begin
            r_outMux   <= w_selected;
            r_outValid <= 1'b1;
        end else begin
            r_outValid <= 1'b0;
        end
    end

    assign bus.outMux   = r_outMux;
    assign bus.outValid = r_outValid;

`else

    // clk and reset have no job in the combinational build.
    // They are folded into a sink so they remain connected.
    logic w_unused;
    assign w_unused = ^{clk, reset};

    assign bus.outMux   = w_selected;
    assign bus.outValid = bus.inValid;

`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_2to1
//  Description : Self-checking bench for mux_2to1, for either build of
//                MUX_OUT_REG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_2to1;

    localparam int WIDTH = 64;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mux_2to1_if #(.WIDTH(WIDTH)) bus ();

    mux_2to1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state for the registered build. It records the last result
    // the output should present.
    logic [WIDTH-1:0] expMux;
    logic             expValid;

    function automatic logic [WIDTH-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Apply one input set and let it take effect.
    // Combinational build: settle for 1 time unit.
    // Registered build: cross one rising edge and sample 1 unit after it.
    // Either way, the reference model is updated from the rules.
    task automatic apply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic v, input logic r);
        bus.inputA        = a;
        bus.inputB        = b;
        bus.controlSignal = c;
        bus.inValid       = v;
        reset             = r;
`ifdef MUX_OUT_REG_EN
        if (r) begin
            expMux   = '0;
            expValid = 1'b0;
        end else if (v) begin
            expMux   = (c === 1'b1) ? b : a;
            expValid = 1'b1;
        end else begin
            expValid = 1'b0;
        end
        @(posedge clk);
        #1;
`else
        expMux   = (c === 1'b1) ? b : a;
        expValid = v;
        #1;
`endif
    endtask

    task automatic test_reset();
`ifdef MUX_OUT_REG_EN
        apply(64'h1111, 64'h2222, 1'b1, 1'b1, 1'b1);
        apply(64'h3333, 64'h4444, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.outMux !== 64'h0) begin
            errors++;
            $display("FAIL reset_mux got %h want %h", bus.outMux, 64'h0);
        end
        checks++;
        if (bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want %b", bus.outValid, 1'b0);
        end
`else
        apply(64'h3333, 64'h4444, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (bus.outMux !== 64'h4444) begin
            errors++;
            $display("FAIL reset_noeffect_mux got %h want %h", bus.outMux, 64'h4444);
        end
        checks++;
        if (bus.outValid !== 1'b1) begin
            errors++;
            $display("FAIL reset_noeffect_valid got %b want %b", bus.outValid, 1'b1);
        end
        apply(64'h3333, 64'h4444, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.outMux !== 64'h3333 || bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_follow got %h/%b want %h/%b", bus.outMux, bus.outValid, 64'h3333, 1'b0);
        end
        apply(64'h3333, 64'h4444, 1'b0, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_combinational();
        apply(64'h0, 64'h1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.outMux !== 64'h0 || bus.outValid !== 1'b1) begin
            errors++;
            $display("FAIL sel_a got %h/%b want %h/%b", bus.outMux, bus.outValid, 64'h0, 1'b1);
        end
        apply(64'h0, 64'h1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.outMux !== 64'h1 || bus.outValid !== 1'b1) begin
            errors++;
            $display("FAIL sel_b got %h/%b want %h/%b", bus.outMux, bus.outValid, 64'h1, 1'b1);
        end
    endtask

    task automatic test_full_width();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a = 64'hFFFF_FFFF_FFFF_FFFF;
        b = 64'hA5A5_5A5A_0F0F_F0F0;
        for (int i = 0; i < 6; i++) begin
            apply(a, b, i[0], 1'b1, 1'b0);
            checks++;
            if (bus.outMux !== (i[0] ? b : a)) begin
                errors++;
                $display("FAIL full_width[%0d] got %h want %h", i, bus.outMux, (i[0] ? b : a));
            end
        end
    endtask

    task automatic test_x_select();
        apply(64'h5, 64'h9, 1'bx, 1'b1, 1'b0);
        checks++;
        if (bus.outMux !== 64'h5) begin
            errors++;
            $display("FAIL x_select got %h want %h", bus.outMux, 64'h5);
        end
    endtask

`ifdef MUX_OUT_REG_EN
    task automatic test_latency_hold();
        apply(64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        apply(64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        // Load the inputs without a clock edge. The registered output must
        // still show the reset state.
        bus.inputA = 64'h1234; bus.controlSignal = 1'b0; bus.inValid = 1'b1; reset = 1'b0;
        #1;
        checks++;
        if (bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got %b want %b", bus.outValid, 1'b0);
        end
        apply(64'h1234, 64'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.outMux !== 64'h1234 || bus.outValid !== 1'b1) begin
            errors++;
            $display("FAIL latency got %h/%b want %h/%b", bus.outMux, bus.outValid, 64'h1234, 1'b1);
        end
        apply(64'hDEAD, 64'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.outMux !== 64'h1234 || bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL hold got %h/%b want %h/%b", bus.outMux, bus.outValid, 64'h1234, 1'b0);
        end
    endtask

    task automatic test_reset_priority();
        apply(64'h0, 64'h1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.outMux !== 64'h0 || bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority got %h/%b want %h/%b", bus.outMux, bus.outValid, 64'h0, 1'b0);
        end
        apply(64'h77, 64'h88, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.outMux !== 64'h88 || bus.outValid !== 1'b1) begin
            errors++;
            $display("FAIL after_reset got %h/%b want %h/%b", bus.outMux, bus.outValid, 64'h88, 1'b1);
        end
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            apply(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            checks++;
            if (bus.outMux !== expMux || bus.outValid !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d] got %h/%b want %h/%b", i, bus.outMux, bus.outValid, expMux, 1'b1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            apply(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0));
            checks++;
            if (bus.outMux !== expMux || bus.outValid !== expValid) begin
                errors++;
                $display("FAIL random[%0d] got %h/%b want %h/%b", i, bus.outMux, bus.outValid, expMux, expValid);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        expMux = '0;
        expValid = 1'b0;
        reset = 1'b1;
        bus.inputA = '0;
        bus.inputB = '0;
        bus.controlSignal = 1'b0;
        bus.inValid = 1'b0;
        @(negedge clk);
        test_reset();
        test_combinational();
        test_full_width();
        test_x_select();
`ifdef MUX_OUT_REG_EN
        test_latency_hold();
        test_reset_priority();
`endif
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
